// File: rtl/canny_pkg.sv
// Shared definitions for the edge-detection pixel pipeline.
// Holds the border-mode encodings, the window-generator FSM state type,
// default frame geometry with the widths derived from it, and small helper
// functions that size kernels and counters.
package canny_pkg;

    // Border handling selected at frame start
    localparam logic [1:0] BM_ZERO     = 2'd0;
    localparam logic [1:0] BM_REPL     = 2'd1;
    localparam logic [1:0] BM_INTERIOR = 2'd2;

    // Window generator frame-level state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } lwg_state_t;

    // Default geometry and the coordinate widths derived from it
    localparam int DEF_IMG_W = 512;
    localparam int DEF_IMG_H = 512;
    localparam int DEF_X_W   = $clog2(DEF_IMG_W);
    localparam int DEF_Y_W   = $clog2(DEF_IMG_H);

    // Kernel radius R for an odd window size K
    function automatic int calc_radius(input int ksize);
        return (ksize - 1) / 2;
    endfunction

    // Bits needed to hold the values 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay for the window generator, built on an inferred RAM.
// dout always shows the sample written DEPTH advances ago, i.e. the entry
// that the next advance overwrites, so the consumer can use it in the same
// cycle as the advance.
// Ports: clk, rst_n (async, active low), adv (shift enable), din (sample
// entering the line), dout (registered sample leaving the line).
module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         ptr_r;
    logic [PW-1:0]         ptr_nxt_s;
    logic [PW-1:0]         rd_addr_s;

    // Ring pointer step, and read-ahead address: on an advance the read
    // targets the slot that becomes current, never the slot being written.
    always_comb begin
        if (ptr_r == PW'(DEPTH - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = ptr_r + PW'(1);
        end
        if (adv) begin
            rd_addr_s = ptr_nxt_s;
        end else begin
            rd_addr_s = ptr_r;
        end
    end

    // RAM write port; contents need no reset because stale entries are
    // always masked by the border logic downstream.
    always_ff @(posedge clk) begin
        if (adv) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Pointer and synchronous read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            dout  <= '0;
        end else begin
            if (adv) begin
                ptr_r <= ptr_nxt_s;
            end
            dout <= mem_r[rd_addr_s];
        end
    end

endmodule

// File: rtl/line_window_gen.sv
// KxK sliding-window generator with valid/ready on both sides.
// Pixels arrive in raster order; each accepted pixel (or flush advance
// after the frame) shifts the taps, and the window centred R lines and R
// pixels behind the newest sample is registered to the output together
// with its centre coordinates. Out-of-frame elements are zeroed or
// replaced by the clamped neighbour (tap mux), or the centre is skipped.
// Ports: border_mode (latched at accepted in_sof), in_* (pixel stream,
// in_sof marks the first pixel), out_* (window, centre x/y, sof/eof).
module line_window_gen
    import canny_pkg::*;
#(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int DATA_WIDTH = 16,
    parameter int KSIZE      = 3
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          border_mode,
    input  logic                                in_sof,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   out_win,
    output logic [$clog2(IMG_W)-1:0]            out_x,
    output logic [$clog2(IMG_H)-1:0]            out_y,
    output logic                                out_sof,
    output logic                                out_eof
);

    localparam int R    = calc_radius(KSIZE);
    localparam int LAG  = R * IMG_W + R;        // advances between newest pixel and centre
    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int PCW  = cnt_width(NPIX);
    localparam int LW   = cnt_width(LAG + 1);
    localparam int KW   = cnt_width(KSIZE);
    localparam int WINW = KSIZE * KSIZE * DATA_WIDTH;

    lwg_state_t            state_r;
    logic [PCW-1:0]        in_cnt_r;
    logic [LW-1:0]         lead_r;
    logic [LW-1:0]         flush_cnt_r;
    logic [XW-1:0]         cx_r;
    logic [YW-1:0]         cy_r;
    logic [1:0]            bm_r;
    logic                  first_r;

    logic [DATA_WIDTH-1:0] taps_r     [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] taps_nxt_s [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] col_s      [KSIZE];
    logic [DATA_WIDTH-1:0] lb_in_s    [KSIZE-1];
    logic [DATA_WIDTH-1:0] lb_out_s   [KSIZE-1];

    logic [DATA_WIDTH-1:0] din_s;
    logic                  acc_s, start_s, adv_s, win_now_s, emit_s, last_s;
    logic [WINW-1:0]       win_s;
    int                    sy_s, sx_s, ty_s, tx_s;
    logic [KW-1:0]         ri_s, ci_s;

    assign in_ready  = (state_r != ST_FLUSH) && (!out_valid || out_ready);
    assign acc_s     = in_valid && in_ready;
    assign start_s   = acc_s && in_sof;
    // Pixels dropped in IDLE do not move the line buffers
    assign adv_s     = (acc_s && (in_sof || (state_r == ST_RUN))) ||
                       ((state_r == ST_FLUSH) && (!out_valid || out_ready));
    assign din_s     = (state_r == ST_FLUSH) ? '0 : in_data;
    assign win_now_s = adv_s && !start_s && (lead_r == LW'(LAG));

    // Line buffer chain: each stage adds one full line of delay
    assign lb_in_s[0] = din_s;
    for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
        if (k > 0) begin : g_chain
            assign lb_in_s[k] = lb_out_s[k-1];
        end
        line_buffer #(
            .DEPTH      (IMG_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line_buffer (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv_s),
            .din   (lb_in_s[k]),
            .dout  (lb_out_s[k])
        );
    end

    // New rightmost tap column: bottom row is the incoming sample, rows above come from the lines
    always_comb begin
        col_s[KSIZE-1] = din_s;
        for (int k = 0; k < KSIZE - 1; k++) begin
            col_s[KSIZE-2-k] = lb_out_s[k];
        end
    end

    // Taps after this advance: shift left by one column, append the new column
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                taps_nxt_s[r][c] = taps_r[r][c+1];
            end
            taps_nxt_s[r][KSIZE-1] = col_s[r];
        end
    end

    // Border mux: tap (r,c) holds the raster neighbour, which is only the true
    // 2-D neighbour when in frame, so out-of-frame elements never use it directly
    always_comb begin
        win_s = '0;
        sy_s  = 0;
        sx_s  = 0;
        ty_s  = 0;
        tx_s  = 0;
        ri_s  = '0;
        ci_s  = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                sy_s = int'(cy_r) + r - R;
                sx_s = int'(cx_r) + c - R;
                if (bm_r == BM_REPL) begin
                    ty_s = (sy_s < 0) ? 0 : ((sy_s >= IMG_H) ? IMG_H - 1 : sy_s);
                    tx_s = (sx_s < 0) ? 0 : ((sx_s >= IMG_W) ? IMG_W - 1 : sx_s);
                    ri_s = KW'(ty_s - int'(cy_r) + R);
                    ci_s = KW'(tx_s - int'(cx_r) + R);
                    win_s[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = taps_nxt_s[ri_s][ci_s];
                end else if ((sy_s >= 0) && (sy_s < IMG_H) && (sx_s >= 0) && (sx_s < IMG_W)) begin
                    win_s[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = taps_nxt_s[r][c];
                end else begin
                    win_s[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = '0;
                end
            end
        end
    end

    // Which centres are emitted, and which one closes the frame
    always_comb begin
        if (bm_r == BM_INTERIOR) begin
            emit_s = win_now_s &&
                     (cx_r >= XW'(R)) && (cx_r < XW'(IMG_W - R)) &&
                     (cy_r >= YW'(R)) && (cy_r < YW'(IMG_H - R));
            last_s = (cx_r == XW'(IMG_W - 1 - R)) && (cy_r == YW'(IMG_H - 1 - R));
        end else begin
            emit_s = win_now_s;
            last_s = (cx_r == XW'(IMG_W - 1)) && (cy_r == YW'(IMG_H - 1));
        end
    end

    // Tap registers advance with the line buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    taps_r[r][c] <= '0;
                end
            end
        end else if (adv_s) begin
            taps_r <= taps_nxt_s;
        end
    end

    // Frame FSM, position counters and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_cnt_r    <= '0;
            lead_r      <= '0;
            flush_cnt_r <= '0;
            cx_r        <= '0;
            cy_r        <= '0;
            bm_r        <= BM_ZERO;
            first_r     <= 1'b0;
            out_valid   <= 1'b0;
            out_win     <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit_s) begin
                out_valid <= 1'b1;
                out_win   <= win_s;
                out_x     <= cx_r;
                out_y     <= cy_r;
                out_sof   <= first_r;
                out_eof   <= last_s;
                first_r   <= 1'b0;
            end
            // Centre walks the frame even for silently skipped centres
            if (win_now_s) begin
                if (cx_r == XW'(IMG_W - 1)) begin
                    cx_r <= '0;
                    cy_r <= (cy_r == YW'(IMG_H - 1)) ? '0 : cy_r + YW'(1);
                end else begin
                    cx_r <= cx_r + XW'(1);
                end
            end
            if (adv_s && (lead_r != LW'(LAG))) begin
                lead_r <= lead_r + LW'(1);
            end
            case (state_r)
                ST_RUN: begin
                    if (acc_s && !in_sof) begin
                        in_cnt_r <= in_cnt_r + PCW'(1);
                        if (in_cnt_r == PCW'(NPIX - 1)) begin
                            state_r     <= ST_FLUSH;
                            flush_cnt_r <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (adv_s) begin
                        flush_cnt_r <= flush_cnt_r + LW'(1);
                        if (flush_cnt_r == LW'(LAG - 1)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // Frame start, also aborting a frame in progress; the sof pixel is index 0
            if (start_s) begin
                state_r  <= ST_RUN;
                in_cnt_r <= PCW'(1);
                lead_r   <= LW'(1);
                cx_r     <= '0;
                cy_r     <= '0;
                first_r  <= 1'b1;
                bm_r     <= ((border_mode == BM_REPL) || (border_mode == BM_INTERIOR)) ?
                            border_mode : BM_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen (8x6 frame, 3x3 window).
// Stimulus pushes expected windows into a queue; a negedge monitor pops
// and compares on every output transfer and checks stability during stalls.
module tb_line_window_gen;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int K    = 3;
    localparam int R    = 1;
    localparam int DW   = 16;
    localparam int WINW = K * K * DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      border_mode = 2'd0;
    logic            in_sof = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [WINW-1:0] out_win;
    logic [2:0]      out_x;
    logic [2:0]      out_y;
    logic            out_sof;
    logic            out_eof;

    always #5 clk = ~clk;

    line_window_gen #(
        .IMG_W      (W),
        .IMG_H      (H),
        .DATA_WIDTH (DW),
        .KSIZE      (K)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .border_mode (border_mode),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_win     (out_win),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_sof     (out_sof),
        .out_eof     (out_eof)
    );

    typedef struct packed {
        logic [2:0]      x;
        logic [2:0]      y;
        logic            sof;
        logic            eof;
        logic [WINW-1:0] win;
    } item_t;

    item_t           exp_q[$];
    int              total = 0;
    int              bad = 0;
    bit              rand_ready = 1'b0;
    bit              chk_en = 1'b1;
    bit              cnt_low = 1'b0;
    int              low_cycles = 0;
    int              win_seen = 0;
    logic [WINW-1:0] cap_win [W*H];

    task automatic check(input string name, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [WINW-1:0] pack9(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5,
                                              input int a6, input int a7, input int a8);
        return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Reference pixel at (x,y) in a frame whose pixel value is base + y*W + x
    function automatic logic [DW-1:0] src_pix(input int base, input int x, input int y, input int mode);
        int xx;
        int yy;
        xx = x;
        yy = y;
        if (x < 0 || x >= W || y < 0 || y >= H) begin
            if (mode != 1) return '0;
            xx = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
            yy = (y < 0) ? 0 : ((y >= H) ? H - 1 : y);
        end
        return DW'(base + yy * W + xx);
    endfunction

    function automatic logic [WINW-1:0] ref_win(input int base, input int x, input int y, input int mode);
        logic [WINW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = src_pix(base, x + c - R, y + r - R, mode);
        return w;
    endfunction

    // Expected windows for the first ncent centres of a frame
    task automatic push_frame(input int base, input int mode, input int ncent);
        item_t tmp[$];
        item_t it;
        for (int c = 0; c < ncent; c++) begin
            int x;
            int y;
            x = c % W;
            y = c / W;
            if (mode != 2 || (x >= R && x < W - R && y >= R && y < H - R)) begin
                it.x   = 3'(x);
                it.y   = 3'(y);
                it.sof = (tmp.size() == 0);
                it.eof = 1'b0;
                it.win = ref_win(base, x, y, mode);
                tmp.push_back(it);
            end
        end
        if (ncent == W * H && tmp.size() > 0) tmp[tmp.size()-1].eof = 1'b1;
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
    endtask

    task automatic drive_one(input logic [DW-1:0] d, input logic sof);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!ok && guard > 2000) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got=0 expected=1 within 2000 cycles");
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input int mode, input int npix, input bit gaps);
        border_mode = 2'(mode);
        for (int p = 0; p < npix; p++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            drive_one(DW'(base + p), p == 0);
        end
    endtask

    task automatic drain(input string name, input int exp_count);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got=%0d windows left expected=0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_count"}, WINW'(win_seen), WINW'(exp_count));
    endtask

    task automatic new_frame();
        win_seen = 0;
        for (int i = 0; i < W * H; i++) cap_win[i] = '0;
    endtask

    // Downstream ready: always 1, or a coin flip per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every transfer, hold-check every stall
    initial begin
        item_t got;
        item_t e;
        item_t held;
        bit    held_vld;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            got = {out_x, out_y, out_sof, out_eof, out_win};
            if (rst_n && chk_en) begin
                if (held_vld) begin
                    total++;
                    if (!out_valid || got !== held) begin
                        bad++;
                        $display("FAIL stall_hold: got valid=%0b x=%0d y=%0d expected valid=1 x=%0d y=%0d",
                                 out_valid, out_x, out_y, held.x, held.y);
                    end
                end
                held_vld = 1'b0;
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_window: got x=%0d y=%0d expected no window", out_x, out_y);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL window: got x=%0d y=%0d sof=%0b eof=%0b win=%0h expected x=%0d y=%0d sof=%0b eof=%0b win=%0h",
                                     got.x, got.y, got.sof, got.eof, got.win, e.x, e.y, e.sof, e.eof, e.win);
                        end
                    end
                    win_seen++;
                    cap_win[int'(out_y) * W + int'(out_x)] = out_win;
                end else if (out_valid) begin
                    held     = got;
                    held_vld = 1'b1;
                end
                if (cnt_low && !in_ready) low_cycles++;
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_out_valid", WINW'(out_valid), '0);
        check("reset_in_ready", WINW'(in_ready), WINW'(1));
        check("reset_out_win", out_win, '0);
        check("reset_xy_sof_eof", WINW'({out_x, out_y, out_sof, out_eof}), '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pixels before any sof are dropped, then a zero-pad frame
        for (int i = 0; i < 5; i++) drive_one(DW'(999), 1'b0);
        new_frame();
        push_frame(0, 0, W * H);
        low_cycles = 0;
        cnt_low = 1'b1;
        send_frame(0, 0, W * H, 1'b0);
        drain("mode0", 48);
        cnt_low = 1'b0;
        check("flush_cycles", WINW'(low_cycles), WINW'(9));
        check("mode0_win_0_0", cap_win[0], pack9(0, 0, 0, 0, 0, 1, 0, 8, 9));
        check("mode0_win_3_2", cap_win[2*W+3], pack9(10, 11, 12, 18, 19, 20, 26, 27, 28));

        // Replicate-edge frame
        new_frame();
        push_frame(0, 1, W * H);
        send_frame(0, 1, W * H, 1'b0);
        drain("mode1", 48);
        check("mode1_win_0_0", cap_win[0], pack9(0, 0, 1, 0, 0, 1, 8, 8, 9));
        check("mode1_win_7_5", cap_win[5*W+7], pack9(38, 39, 39, 46, 47, 47, 46, 47, 47));

        // Interior-only frame
        new_frame();
        push_frame(0, 2, W * H);
        send_frame(0, 2, W * H, 1'b0);
        drain("mode2", 24);

        // Backpressure and input gaps
        rand_ready = 1'b1;
        new_frame();
        push_frame(3, 0, W * H);
        send_frame(3, 0, W * H, 1'b1);
        drain("stall_mode0", 48);
        new_frame();
        push_frame(5, 1, W * H);
        send_frame(5, 1, W * H, 1'b1);
        drain("stall_mode1", 48);
        rand_ready = 1'b0;

        // Frame aborted by a new sof after 20 pixels: 11 old centres, then the new frame
        new_frame();
        push_frame(100, 0, 11);
        push_frame(0, 0, W * H);
        send_frame(100, 0, 20, 1'b0);
        send_frame(0, 0, W * H, 1'b0);
        drain("abort", 59);

        // Asynchronous reset in mid-frame
        chk_en = 1'b0;
        send_frame(200, 1, 20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", WINW'(out_valid), '0);
        check("midrst_in_ready", WINW'(in_ready), WINW'(1));
        check("midrst_out_win", out_win, '0);
        check("midrst_xy_sof_eof", WINW'({out_x, out_y, out_sof, out_eof}), '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        new_frame();
        push_frame(7, 1, W * H);
        send_frame(7, 1, W * H, 1'b0);
        drain("after_reset", 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Parametrised KxK sliding-window generator; successor to the fixed 3x3 gradient window block.
- Sits between a pixel stream source (smoothing/gradient stage) and any KxK kernel stage (Sobel, NMS, hysteresis).
- Uses inferred line buffers instead of vendor shift-RAM IP.
- Adds valid/ready backpressure, explicit frame start, selectable border handling, end-of-frame flush and output coordinates.

Parameters:
- IMG_W, 512, pixels per line (>= KSIZE+1).
- IMG_H, 512, lines per frame (>= KSIZE+1).
- DATA_WIDTH, 16, bits per pixel.
- KSIZE, 3, window size; odd, legal values 3, 5, 7. R = (KSIZE-1)/2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- border_mode  in  2  0 = zero pad, 1 = replicate edge, 2 = interior only, 3 = reserved (treated as 0). Sampled at accepted sof.
- in_sof  in  1  qualifies the first pixel of a frame; valid only with in_valid.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_WIDTH  pixel, raster order.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- out_win  out  KSIZE*KSIZE*DATA_WIDTH  window, row-major; element (r,c) at index r*KSIZE+c; (0,0) is top-left; LSBs hold (0,0).
- out_x  out  clog2(IMG_W)  centre column.
- out_y  out  clog2(IMG_H)  centre row.
- out_sof  out  1  first window of frame.
- out_eof  out  1  last window of frame.

Behaviour:
- Reset: all outputs 0 except in_ready = 1. Counters, line buffers and flush state are cleared. State = IDLE.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output transferred when out_valid & out_ready.
  - in_ready = (state != FLUSH) & (!out_valid | out_ready).
  - While out_valid & !out_ready, out_win, out_x, out_y, out_sof and out_eof hold stable.
- States:
  - IDLE: pixels without in_sof are dropped (in_ready = 1).
  - IDLE -> RUN on accepted in_sof.
  - RUN -> FLUSH after pixel W*H-1 is accepted.
  - FLUSH -> IDLE after R*IMG_W+R internal advance cycles. Each advance happens only when !out_valid | out_ready.
  - In FLUSH, advances act as phantom pixels: value 0, never visible in the window.
- Accepted in_sof in RUN aborts the current frame. Counters restart at (0,0) with this pixel, and no further windows of the old frame are emitted.
- Linear index p counts accepted pixels plus flush advances from 0. The centre index is c = p - (R*IMG_W + R).
- When c >= 0, a window for centre (c mod IMG_W, c div IMG_W) is produced. out_valid rises the cycle after the advance that creates it (latency 1 advance).
- Mode 2 emits only centres with R <= x < IMG_W-R and R <= y < IMG_H-R; other centres advance silently.
- Window sourcing: K-1 line buffers (depth IMG_W) plus KxK tap registers.
- Element (r,c) maps to source pixel (y+r-R, x+c-R):
  - Out of frame, mode 0: value 0.
  - Out of frame, mode 1: value of the pixel at clamped coordinates. This is always present in the taps, so it is a tap mux and never a re-read.
  - Raster wrap from the previous/next line must never leak into the window.
- out_sof is set on the first emitted window of the frame. out_eof is set on the last: (IMG_W-1,IMG_H-1), or (IMG_W-1-R,IMG_H-1-R) in mode 2.
- Exactly IMG_W*IMG_H windows per frame in modes 0/1; (IMG_W-2R)*(IMG_H-2R) in mode 2.
- Line buffers and taps advance only on accepted pixels or flush advances; no gated clocks.

Decomposition:
- Shared package canny_pkg:
  - border mode constants BM_ZERO, BM_REPL, BM_INTERIOR.
  - clog2-derived width localparams.
  - function computing R.
- Sub-module line_buffer: single-row delay of IMG_W x DATA_WIDTH, inferred RAM, with advance enable and synchronous read. Instantiated KSIZE-1 times.
- Top holds the FSM, counters, taps, border mux and output register.

Test Plan:
- IMG_W=8, IMG_H=6, KSIZE=3, mode 0, pixel value = y*8+x, out_ready=1:
  - exactly 48 windows, first at centre (0,0) with out_sof;
  - window at (0,0) = {0,0,0, 0,0,1, 0,8,9};
  - window at (3,2) = {10,11,12, 18,19,20, 26,27,28};
  - last window at (7,5) with out_eof;
  - in_ready low for exactly 9 flush cycles.
- Same frame, mode 1: window at (0,0) = {0,0,1, 0,0,1, 8,8,9}; window at (7,5) = {38,39,39, 46,47,47, 46,47,47}.
- Same frame, mode 2: 24 windows; first at (1,1) with out_sof; last at (6,4) with out_eof.
- Random out_ready (50%) and in_valid gaps, modes 0 and 1: window stream and coordinates bit-identical to the no-stall run; outputs stable during stalls.
- KSIZE=5, IMG_W=8, IMG_H=8, mode 0: 64 windows; window at (0,0) has 16 zero elements; flush is 2*8+2 = 18 cycles.
- Fault cases:
  - in_sof re-asserted after 20 pixels: only the new frame's 48 windows follow.
  - rst_n pulsed mid-frame: all outputs 0 and in_ready = 1 asynchronously; next in_sof frame is correct.
  - pixels before any in_sof: dropped.
